control_unit_p: RTL and testbench
=================================

# control_unit_p

Parametrised multicycle control FSM for the accumulator/register-file processor. It sequences fetch, decode and execute micro-steps from a registered instruction word. It drives ALU op, datapath mux selects, register-file ports, immediate/jump fields and data-RAM write. Compared with the fixed 20-bit controller, it adds:
- generic field widths;
- synchronous reset;
- single-cycle write strobes;
- configurable branch polarity;
- illegal-opcode trapping;
- a restartable halt.

## Interface
- OPW, 4, opcode width (instruction MSBs)
- RW, 4, register-index width
- IMMW, 12, immediate width; must be ≥ 2·RW
- JW, 6, jump-target width; must be ≤ RW+IMMW
- IW, OPW+RW+IMMW, instruction width (derived; do not override)
- Z_TAKEN, 1'b0, level of z for which JMPZ is taken
- Field map:
  - op = instr[IW-1 -: OPW]
  - ra = instr[RW+IMMW-1 -: RW]
  - rb = instr[IMMW-1 -: RW]
  - imm = instr[IMMW-1:0]
  - tgt = instr[RW+IMMW-1 -: JW]

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- z  in  1  ALU zero flag
- instruction  in  IW  current IR contents
- start  in  1  restart pulse, honoured only in HALT
- ir_load  out  1  IR write strobe
- alu_op  out  2  00 idle, 01 add, 10 sub, 11 mul
- m1  out  2  RF write-data select: 01 DRAM, 10 imm, 11 ALU
- m2  out  1  DRAM address/data select
- m3  out  2  PC select: 00 hold, 01 pc+1, 10 gamma, 11 trap vector
- m4  out  1  immediate/register address select
- rpa, rpb, wpn  out  RW  RF read A, read B, write index
- rst_en, write_en, write_dram  out  1  RF clear, RF write, DRAM write strobes
- alpha  out  IMMW  immediate
- gamma  out  JW  jump target
- done  out  1  high while halted
- illegal  out  1  sticky illegal-opcode flag

## Operation
- All outputs are registered.
- Strobes (ir_load, rst_en, write_en, write_dram) default to 0 every cycle and pulse high for exactly one cycle.
- m3 defaults to 00 every cycle.
- All other outputs hold their value until rewritten.

States and actions:
- FETCH1: ir_load=1, alu_op=00 → FETCH2
- FETCH2: m3=01 → DECODE
- DECODE: branch on op:
  - 2 RST; 3 WRITE; 4 LDI1; 5 MUL; 6 LD1; 7 MV; 8 ADD; 9 INC1
  - 10 SUB; 11 JMPZ; 12 JMP; 13 ST1; 14 HALT; others → TRAP
  - Opcodes are the low 4 bits of op; upper op bits must be zero, otherwise TRAP.
- RST: rst_en=1, wpn=ra → FETCH1
- WRITE: write_en=1, wpn=ra, alpha=imm, m1=10 → FETCH1
- LDI1: alpha=imm, m4=0 → LDI2: m2=1 → LDI3: m1=01, wpn=ra, write_en=1 → FETCH1
- MUL/ADD/SUB: alu_op=11/01/10, rpa=ra, rpb=rb → FETCH1
- JMPZ: if z==Z_TAKEN then gamma=tgt, m3=10 → FETCH1
- JMP: gamma=tgt, m3=10 → FETCH1
- ST1: m4=1, rpa=rb → ST2: rpb=ra, m2=0, write_dram=1 → FETCH1
- INC1: rpa=ra, rpb=all-ones (constant-1 register), alu_op=01 → INC2: m1=11, wpn=ra, write_en=1 → FETCH1
- LD1: m4=1, rpa=rb → LD2: m2=1 → LD3: m1=01, wpn=ra, write_en=1 → FETCH1
- MV: m1=11, wpn=ra, write_en=1 → FETCH1
- HALT: done=1 (held); start=1 → FETCH1 with done=0 next cycle. rst also exits.
- TRAP: illegal←1, m3=11 for one cycle → FETCH1. illegal is cleared only by rst.

## Timing
- Reset values:
  - state = FETCH1
  - every output 0, including alu_op, m1..m4, rpa/rpb/wpn, alpha, gamma, done and illegal
- rst during any state aborts it. The cycle after rst has all strobes 0 and the FSM in FETCH1.
- Cycle counts from FETCH1 to the next FETCH1 (FETCH1/FETCH2/DECODE plus execute):
  - 4 cycles: RST, WRITE, ALU ops, JMP, JMPZ, MV, TRAP
  - 5 cycles: ST, INC
  - 6 cycles: LDI, LD
- z is sampled only in the JMPZ cycle.
- instruction must be stable from DECODE to the last execute state.
- rst and start together: rst wins.
- start outside HALT is ignored.

## Test plan
- Reset mid-LD2 (rst=1 one cycle) → next cycle state FETCH1, write_en=0, every output 0.
- ADD r3,r5 (op=8, ra=3, rb=5), defaults → alu_op=01, rpa=3, rpb=5 on cycle 4; ir_load pulses on cycles 1 and 5.
- LDI r2,#0xABC → alpha=0xABC and m4=0 in cycle 4, m2=1 in cycle 5; write_en=1 for one cycle with wpn=2, m1=01 in cycle 6.
- JMPZ tgt=0x15 with z=0 then z=1 (Z_TAKEN=0) → first: gamma=0x15, m3=10 one cycle; second: m3=00, gamma unchanged.
- Opcode 0xF → illegal=1 and stays 1, m3=11 one cycle, fetch resumes. Then op=14 → done=1 held; start pulse → FETCH1, done=0.
- Re-run ADD and INC with OPW=5, RW=5, IMMW=16, JW=8 → fields decode at the new positions; INC rpb=31.

Source files
------------

// File: rtl/control_unit_p_if.sv
// Bundle between the multicycle controller and the datapath it sequences.
// master = controller side, slave = datapath side.
interface control_unit_p_if #(
  parameter int OPW  = 4,
  parameter int RW   = 4,
  parameter int IMMW = 12,
  parameter int JW   = 6,
  parameter int IW   = OPW + RW + IMMW
);
  logic            z;
  logic [IW-1:0]   instruction;
  logic            start;

  logic            ir_load;
  logic [1:0]      alu_op;
  logic [1:0]      m1;
  logic            m2;
  logic [1:0]      m3;
  logic            m4;
  logic [RW-1:0]   rpa;
  logic [RW-1:0]   rpb;
  logic [RW-1:0]   wpn;
  logic            rst_en;
  logic            write_en;
  logic            write_dram;
  logic [IMMW-1:0] alpha;
  logic [JW-1:0]   gamma;
  logic            done;
  logic            illegal;

  modport master (
    input  z, instruction, start,
    output ir_load, alu_op, m1, m2, m3, m4, rpa, rpb, wpn,
           rst_en, write_en, write_dram, alpha, gamma, done, illegal
  );

  modport slave (
    output z, instruction, start,
    input  ir_load, alu_op, m1, m2, m3, m4, rpa, rpb, wpn,
           rst_en, write_en, write_dram, alpha, gamma, done, illegal
  );
endinterface

// File: rtl/control_unit_p.sv
// Multicycle fetch/decode/execute controller for the accumulator/register-file
// processor. Outputs are registered, so each state's actions show one cycle later.
//
// state  | meaning
// FETCH1 | pulse ir_load, clear alu_op
// FETCH2 | advance pc (m3=01)
// DECODE | branch on opcode of the loaded IR
// RST    | clear RF entry ra
// WRITE  | RF[ra] <- imm
// LDI1-3 | RF[ra] <- DRAM[imm]
// MUL/ADD/SUB | ALU op on ra, rb
// JMPZ   | jump to tgt when z == Z_TAKEN
// JMP    | jump to tgt
// ST1-2  | DRAM[RF[rb]] <- RF[ra]
// INC1-2 | RF[ra] <- RF[ra] + 1
// LD1-3  | RF[ra] <- DRAM[RF[rb]]
// MV     | RF[ra] <- ALU result
// HALT   | done held until start
// TRAP   | set sticky illegal, pc <- trap vector
module control_unit_p #(
  parameter int   OPW     = 4,
  parameter int   RW      = 4,
  parameter int   IMMW    = 12,
  parameter int   JW      = 6,
  parameter int   IW      = OPW + RW + IMMW,
  parameter logic Z_TAKEN = 1'b0
) (
  input logic              clk,
  input logic              rst,
  control_unit_p_if.master bus
);

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_DECODE,
    S_RST, S_WRITE,
    S_LDI1, S_LDI2, S_LDI3,
    S_MUL, S_ADD, S_SUB,
    S_JMPZ, S_JMP,
    S_ST1, S_ST2,
    S_INC1, S_INC2,
    S_LD1, S_LD2, S_LD3,
    S_MV, S_HALT, S_TRAP
  } state_t;

  state_t state;
  state_t dec_state;

  logic [OPW-1:0]  op;
  logic [3:0]      code;
  logic            op_hi_zero;
  logic [RW-1:0]   ra;
  logic [RW-1:0]   rb;
  logic [IMMW-1:0] imm;
  logic [JW-1:0]   tgt;

  assign op         = bus.instruction[IW-1 -: OPW];
  assign code       = op[3:0];
  assign op_hi_zero = ((op >> 4) == '0);
  assign ra         = bus.instruction[RW+IMMW-1 -: RW];
  assign rb         = bus.instruction[IMMW-1 -: RW];
  assign imm        = bus.instruction[IMMW-1:0];
  assign tgt        = bus.instruction[RW+IMMW-1 -: JW];

  // Any opcode bit above the 4-bit code field being set is treated as illegal.
  always_comb begin
    dec_state = S_TRAP;
    if (op_hi_zero) begin
      case (code)
        4'd2:    dec_state = S_RST;
        4'd3:    dec_state = S_WRITE;
        4'd4:    dec_state = S_LDI1;
        4'd5:    dec_state = S_MUL;
        4'd6:    dec_state = S_LD1;
        4'd7:    dec_state = S_MV;
        4'd8:    dec_state = S_ADD;
        4'd9:    dec_state = S_INC1;
        4'd10:   dec_state = S_SUB;
        4'd11:   dec_state = S_JMPZ;
        4'd12:   dec_state = S_JMP;
        4'd13:   dec_state = S_ST1;
        4'd14:   dec_state = S_HALT;
        default: dec_state = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FETCH1;
      bus.ir_load    <= 1'b0;
      bus.alu_op     <= 2'b00;
      bus.m1         <= 2'b00;
      bus.m2         <= 1'b0;
      bus.m3         <= 2'b00;
      bus.m4         <= 1'b0;
      bus.rpa        <= '0;
      bus.rpb        <= '0;
      bus.wpn        <= '0;
      bus.rst_en     <= 1'b0;
      bus.write_en   <= 1'b0;
      bus.write_dram <= 1'b0;
      bus.alpha      <= '0;
      bus.gamma      <= '0;
      bus.done       <= 1'b0;
      bus.illegal    <= 1'b0;
    end else begin
      // strobes and pc select fall back every cycle; the rest hold
      bus.ir_load    <= 1'b0;
      bus.rst_en     <= 1'b0;
      bus.write_en   <= 1'b0;
      bus.write_dram <= 1'b0;
      bus.m3         <= 2'b00;
      case (state)
        S_FETCH1: begin
          bus.ir_load <= 1'b1;
          bus.alu_op  <= 2'b00;
          state       <= S_FETCH2;
        end
        S_FETCH2: begin
          bus.m3 <= 2'b01;
          state  <= S_DECODE;
        end
        S_DECODE: state <= dec_state;
        S_RST: begin
          bus.rst_en <= 1'b1;
          bus.wpn    <= ra;
          state      <= S_FETCH1;
        end
        S_WRITE: begin
          bus.write_en <= 1'b1;
          bus.wpn      <= ra;
          bus.alpha    <= imm;
          bus.m1       <= 2'b10;
          state        <= S_FETCH1;
        end
        S_LDI1: begin
          bus.alpha <= imm;
          bus.m4    <= 1'b0;
          state     <= S_LDI2;
        end
        S_LDI2: begin
          bus.m2 <= 1'b1;
          state  <= S_LDI3;
        end
        S_LDI3, S_LD3: begin
          bus.m1       <= 2'b01;
          bus.wpn      <= ra;
          bus.write_en <= 1'b1;
          state        <= S_FETCH1;
        end
        S_MUL, S_ADD, S_SUB: begin
          bus.alu_op <= (state == S_MUL) ? 2'b11 :
                        (state == S_ADD) ? 2'b01 : 2'b10;
          bus.rpa    <= ra;
          bus.rpb    <= rb;
          state      <= S_FETCH1;
        end
        S_JMPZ: begin
          if (bus.z == Z_TAKEN) begin
            bus.gamma <= tgt;
            bus.m3    <= 2'b10;
          end
          state <= S_FETCH1;
        end
        S_JMP: begin
          bus.gamma <= tgt;
          bus.m3    <= 2'b10;
          state     <= S_FETCH1;
        end
        S_ST1, S_LD1: begin
          bus.m4  <= 1'b1;
          bus.rpa <= rb;
          state   <= (state == S_ST1) ? S_ST2 : S_LD2;
        end
        S_ST2: begin
          bus.rpb        <= ra;
          bus.m2         <= 1'b0;
          bus.write_dram <= 1'b1;
          state          <= S_FETCH1;
        end
        // the all-ones register index holds the constant 1
        S_INC1: begin
          bus.rpa    <= ra;
          bus.rpb    <= '1;
          bus.alu_op <= 2'b01;
          state      <= S_INC2;
        end
        S_INC2, S_MV: begin
          bus.m1       <= 2'b11;
          bus.wpn      <= ra;
          bus.write_en <= 1'b1;
          state        <= S_FETCH1;
        end
        S_LD2: begin
          bus.m2 <= 1'b1;
          state  <= S_LD3;
        end
        S_HALT: begin
          if (bus.start) begin
            bus.done <= 1'b0;
            state    <= S_FETCH1;
          end else begin
            bus.done <= 1'b1;
          end
        end
        S_TRAP: begin
          bus.illegal <= 1'b1;
          bus.m3      <= 2'b11;
          state       <= S_FETCH1;
        end
        default: state <= S_FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_p.sv
// Directed bench for control_unit_p: an instruction-level model predicts the
// outputs of every cycle for two parameter sets (defaults and a wide variant).
module tb_control_unit_p;

  typedef struct packed {
    logic        ir_load;
    logic [1:0]  alu_op;
    logic [1:0]  m1;
    logic        m2;
    logic [1:0]  m3;
    logic        m4;
    logic [7:0]  rpa;
    logic [7:0]  rpb;
    logic [7:0]  wpn;
    logic        rst_en;
    logic        write_en;
    logic        write_dram;
    logic [15:0] alpha;
    logic [7:0]  gamma;
    logic        done;
    logic        illegal;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_w = 1'b1;
  logic        z_w = 1'b0;
  logic        start_w = 1'b0;
  logic [31:0] instr_w = '0;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    chk_en = 1'b0;
  int    sel = 0;
  outs_t exp_o = '0;
  outs_t m = '0;
  outs_t act;

  int opw = 4, rw = 4, immw = 12, jw = 6;
  logic ztk = 1'b0;
  int steps = 0, stop_at = -1;
  bit stopped = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_unit_p_if #(.OPW(4), .RW(4), .IMMW(12), .JW(6)) if_a ();
  control_unit_p_if #(.OPW(5), .RW(5), .IMMW(16), .JW(8)) if_b ();

  assign if_a.z = z_w;
  assign if_a.start = start_w;
  assign if_a.instruction = instr_w[19:0];
  assign if_b.z = z_w;
  assign if_b.start = start_w;
  assign if_b.instruction = instr_w[25:0];

  control_unit_p #(.OPW(4), .RW(4), .IMMW(12), .JW(6), .Z_TAKEN(1'b0))
    dut_a (.clk(clk), .rst(rst_w), .bus(if_a));
  control_unit_p #(.OPW(5), .RW(5), .IMMW(16), .JW(8), .Z_TAKEN(1'b1))
    dut_b (.clk(clk), .rst(rst_w), .bus(if_b));

  always_comb begin
    act = '0;
    if (sel == 0) begin
      act.ir_load = if_a.ir_load;  act.alu_op = if_a.alu_op;
      act.m1 = if_a.m1;  act.m2 = if_a.m2;  act.m3 = if_a.m3;  act.m4 = if_a.m4;
      act.rpa[3:0] = if_a.rpa;  act.rpb[3:0] = if_a.rpb;  act.wpn[3:0] = if_a.wpn;
      act.rst_en = if_a.rst_en;  act.write_en = if_a.write_en;
      act.write_dram = if_a.write_dram;
      act.alpha[11:0] = if_a.alpha;  act.gamma[5:0] = if_a.gamma;
      act.done = if_a.done;  act.illegal = if_a.illegal;
    end else begin
      act.ir_load = if_b.ir_load;  act.alu_op = if_b.alu_op;
      act.m1 = if_b.m1;  act.m2 = if_b.m2;  act.m3 = if_b.m3;  act.m4 = if_b.m4;
      act.rpa[4:0] = if_b.rpa;  act.rpb[4:0] = if_b.rpb;  act.wpn[4:0] = if_b.wpn;
      act.rst_en = if_b.rst_en;  act.write_en = if_b.write_en;
      act.write_dram = if_b.write_dram;
      act.alpha = if_b.alpha;  act.gamma = if_b.gamma;
      act.done = if_b.done;  act.illegal = if_b.illegal;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cfg=%0d cyc=%0d actual=%h expected=%h", nm, sel, cyc, a, e);
    end
  endtask

  // single compare process: every output, every cycle, against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ir_load",    32'(act.ir_load),    32'(exp_o.ir_load));
      chk("alu_op",     32'(act.alu_op),     32'(exp_o.alu_op));
      chk("m1",         32'(act.m1),         32'(exp_o.m1));
      chk("m2",         32'(act.m2),         32'(exp_o.m2));
      chk("m3",         32'(act.m3),         32'(exp_o.m3));
      chk("m4",         32'(act.m4),         32'(exp_o.m4));
      chk("rpa",        32'(act.rpa),        32'(exp_o.rpa));
      chk("rpb",        32'(act.rpb),        32'(exp_o.rpb));
      chk("wpn",        32'(act.wpn),        32'(exp_o.wpn));
      chk("rst_en",     32'(act.rst_en),     32'(exp_o.rst_en));
      chk("write_en",   32'(act.write_en),   32'(exp_o.write_en));
      chk("write_dram", 32'(act.write_dram), 32'(exp_o.write_dram));
      chk("alpha",      32'(act.alpha),      32'(exp_o.alpha));
      chk("gamma",      32'(act.gamma),      32'(exp_o.gamma));
      chk("done",       32'(act.done),       32'(exp_o.done));
      chk("illegal",    32'(act.illegal),    32'(exp_o.illegal));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t clr(input outs_t p);
    outs_t s = p;
    s.ir_load = 1'b0; s.rst_en = 1'b0; s.write_en = 1'b0;
    s.write_dram = 1'b0; s.m3 = 2'b00;
    return s;
  endfunction

  // one controller cycle: s is what the outputs must show after the next edge
  task automatic adv(input outs_t s);
    if (stopped) return;
    tick();
    exp_o = s;
    m = s;
    steps++;
    if (steps == stop_at) stopped = 1'b1;
  endtask

  task automatic do_reset(input logic with_start);
    rst_w = 1'b1;
    start_w = with_start;
    tick();
    m = '0;
    exp_o = '0;
    rst_w = 1'b0;
    start_w = 1'b0;
    stopped = 1'b0;
    stop_at = -1;
  endtask

  function automatic int mask(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic logic [31:0] mk_r(input int op, input int ra, input int rb);
    return 32'((op << (rw + immw)) | (ra << immw) | (rb << (immw - rw)));
  endfunction
  function automatic logic [31:0] mk_i(input int op, input int ra, input int imm);
    return 32'((op << (rw + immw)) | (ra << immw) | imm);
  endfunction
  function automatic logic [31:0] mk_j(input int op, input int tgt);
    return 32'((op << (rw + immw)) | (tgt << (rw + immw - jw)));
  endfunction

  // halt_cycles < 0 leaves the controller parked in HALT
  task automatic issue(input logic [31:0] w, input logic zv, input int halt_cycles);
    int op, ra, rb, imm, tgt;
    outs_t s;
    op  = int'(w >> (rw + immw)) & mask(opw);
    ra  = int'(w >> immw) & mask(rw);
    rb  = int'(w >> (immw - rw)) & mask(rw);
    imm = int'(w) & mask(immw);
    tgt = int'(w >> (rw + immw - jw)) & mask(jw);
    instr_w = w;
    z_w = zv;
    steps = 0;
    s = clr(m); s.ir_load = 1'b1; s.alu_op = 2'b00; adv(s);
    s = clr(m); s.m3 = 2'b01; adv(s);
    s = clr(m); adv(s);
    if (op > 15) op = 0;
    case (op)
      2:  begin s = clr(m); s.rst_en = 1'b1; s.wpn = 8'(ra); adv(s); end
      3:  begin s = clr(m); s.write_en = 1'b1; s.wpn = 8'(ra); s.alpha = 16'(imm);
                s.m1 = 2'b10; adv(s); end
      4, 6: begin
        s = clr(m);
        if (op == 4) begin s.alpha = 16'(imm); s.m4 = 1'b0; end
        else begin s.m4 = 1'b1; s.rpa = 8'(rb); end
        adv(s);
        s = clr(m); s.m2 = 1'b1; adv(s);
        s = clr(m); s.m1 = 2'b01; s.wpn = 8'(ra); s.write_en = 1'b1; adv(s);
      end
      5, 8, 10: begin
        s = clr(m);
        s.alu_op = (op == 5) ? 2'b11 : (op == 8) ? 2'b01 : 2'b10;
        s.rpa = 8'(ra); s.rpb = 8'(rb); adv(s);
      end
      7:  begin s = clr(m); s.m1 = 2'b11; s.wpn = 8'(ra); s.write_en = 1'b1; adv(s); end
      9:  begin
        s = clr(m); s.rpa = 8'(ra); s.rpb = 8'(mask(rw)); s.alu_op = 2'b01; adv(s);
        s = clr(m); s.m1 = 2'b11; s.wpn = 8'(ra); s.write_en = 1'b1; adv(s);
      end
      11, 12: begin
        s = clr(m);
        if (op == 12 || zv == ztk) begin s.gamma = 8'(tgt); s.m3 = 2'b10; end
        adv(s);
      end
      13: begin
        s = clr(m); s.m4 = 1'b1; s.rpa = 8'(rb); adv(s);
        s = clr(m); s.rpb = 8'(ra); s.m2 = 1'b0; s.write_dram = 1'b1; adv(s);
      end
      14: begin
        if (halt_cycles < 0) begin
          s = clr(m); s.done = 1'b1; adv(s);
        end else begin
          for (int i = 0; i < halt_cycles; i++) begin
            s = clr(m); s.done = 1'b1; adv(s);
          end
          start_w = 1'b1;
          s = clr(m); s.done = 1'b0; adv(s);
          start_w = 1'b0;
        end
      end
      default: begin s = clr(m); s.illegal = 1'b1; s.m3 = 2'b11; adv(s); end
    endcase
  endtask

  initial begin
    tick();
    tick();
    m = '0;
    exp_o = '0;
    rst_w = 1'b0;
    chk_en = 1'b1;
    chk("rst_done", 32'(act.done), 32'h0);
    chk("rst_illegal", 32'(act.illegal), 32'h0);

    // default configuration
    issue(mk_r(8, 3, 5), 1'b0, 0);
    chk("add_alu_op", 32'(act.alu_op), 32'h1);
    chk("add_rpa", 32'(act.rpa), 32'h3);
    chk("add_rpb", 32'(act.rpb), 32'h5);
    issue(mk_i(4, 2, 12'hABC), 1'b0, 0);
    chk("ldi_alpha", 32'(act.alpha), 32'hABC);
    chk("ldi_m4", 32'(act.m4), 32'h0);
    chk("ldi_m2", 32'(act.m2), 32'h1);
    chk("ldi_we", 32'(act.write_en), 32'h1);
    chk("ldi_wpn", 32'(act.wpn), 32'h2);
    chk("ldi_m1", 32'(act.m1), 32'h1);
    issue(mk_i(3, 7, 12'h123), 1'b0, 0);
    issue(mk_r(7, 4, 0), 1'b0, 0);
    issue(mk_r(10, 1, 2), 1'b1, 0);
    issue(mk_r(5, 6, 9), 1'b0, 0);
    issue(mk_r(13, 1, 2), 1'b0, 0);
    chk("st_rpa", 32'(act.rpa), 32'h2);
    chk("st_rpb", 32'(act.rpb), 32'h1);
    issue(mk_r(6, 5, 8), 1'b0, 0);
    issue(mk_r(9, 10, 0), 1'b0, 0);
    chk("inc_rpb", 32'(act.rpb), 32'hF);
    issue(mk_r(2, 11, 0), 1'b0, 0);
    issue(mk_j(12, 6'h2A), 1'b0, 0);
    issue(mk_j(11, 6'h15), 1'b0, 0);
    chk("jmpz_taken_m3", 32'(act.m3), 32'h2);
    chk("jmpz_taken_gamma", 32'(act.gamma), 32'h15);
    issue(mk_j(11, 6'h0B), 1'b1, 0);
    chk("jmpz_not_m3", 32'(act.m3), 32'h0);
    chk("jmpz_not_gamma", 32'(act.gamma), 32'h15);

    issue(mk_r(15, 0, 0), 1'b0, 0);
    chk("trap_illegal", 32'(act.illegal), 32'h1);
    chk("trap_m3", 32'(act.m3), 32'h3);
    start_w = 1'b1;
    issue(mk_r(8, 1, 1), 1'b0, 0);
    start_w = 1'b0;
    chk("illegal_sticky", 32'(act.illegal), 32'h1);
    issue(mk_r(0, 0, 0), 1'b0, 0);
    issue(mk_r(1, 0, 0), 1'b0, 0);
    issue(mk_r(14, 0, 0), 1'b0, 3);
    chk("halt_exit_done", 32'(act.done), 32'h0);
    issue(mk_r(14, 0, 0), 1'b0, 0);
    issue(mk_r(8, 2, 3), 1'b0, 0);

    // rst aborts an LD in its second execute state
    stop_at = 4;
    issue(mk_r(6, 9, 4), 1'b0, 0);
    do_reset(1'b0);
    chk("abort_we", 32'(act.write_en), 32'h0);
    chk("abort_illegal", 32'(act.illegal), 32'h0);
    issue(mk_r(6, 9, 4), 1'b0, 0);

    // rst beats start while halted
    issue(mk_r(15, 0, 0), 1'b0, 0);
    issue(mk_r(14, 0, 0), 1'b0, -1);
    tick(); exp_o = m;
    chk("halt_held", 32'(act.done), 32'h1);
    do_reset(1'b1);
    chk("rst_vs_start_illegal", 32'(act.illegal), 32'h0);
    chk("rst_vs_start_done", 32'(act.done), 32'h0);
    issue(mk_r(8, 3, 5), 1'b0, 0);

    // wide configuration
    chk_en = 1'b0;
    sel = 1; opw = 5; rw = 5; immw = 16; jw = 8; ztk = 1'b1;
    do_reset(1'b0);
    chk_en = 1'b1;
    issue(mk_r(8, 17, 30), 1'b0, 0);
    chk("b_add_rpa", 32'(act.rpa), 32'd17);
    chk("b_add_rpb", 32'(act.rpb), 32'd30);
    issue(mk_r(9, 20, 0), 1'b0, 0);
    chk("b_inc_rpb", 32'(act.rpb), 32'd31);
    chk("b_inc_wpn", 32'(act.wpn), 32'd20);
    issue(mk_i(4, 9, 16'hBEEF), 1'b0, 0);
    chk("b_ldi_alpha", 32'(act.alpha), 32'hBEEF);
    issue(mk_j(12, 8'hA5), 1'b0, 0);
    chk("b_jmp_gamma", 32'(act.gamma), 32'hA5);
    issue(mk_j(11, 8'h3C), 1'b1, 0);
    chk("b_jmpz_gamma", 32'(act.gamma), 32'h3C);
    issue(mk_j(11, 8'h11), 1'b0, 0);
    chk("b_jmpz_not", 32'(act.gamma), 32'h3C);
    issue(mk_r(18, 0, 0), 1'b0, 0);
    chk("b_trap_hi_op", 32'(act.illegal), 32'h1);
    issue(mk_r(13, 3, 4), 1'b0, 0);
    issue(mk_r(14, 0, 0), 1'b0, 2);
    issue(mk_r(10, 1, 2), 1'b0, 0);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
